// File: rtl/pushbutton_conditioner.sv
// Push-button front end: two-flop synchroniser, per-channel debounce with
// registered press/release pulses, and a run/stop toggle on channel 0 that
// feeds the stopwatch counter stage.
module pushbutton_conditioner #(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               run,
  output logic               start_pulse,
  output logic               stop_pulse
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  // Last count value before a differing level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_t;

  logic [NUM_BTN-1:0] r_s1;
  logic [NUM_BTN-1:0] r_s2;
  logic [NUM_BTN-1:0] w_stable;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_release;

  run_state_t r_state;
  logic       r_start;
  logic       r_stop;

  // Two-flop synchroniser; only r_s2 is used by the debounce logic.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_press;
    logic             r_release;

    // Debounce: a differing level must persist for DEBOUNCE_CYCLES samples;
    // any sample matching the accepted level restarts the count.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_cnt     <= '0;
        r_stable  <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        if (r_s2[g] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt < CNT_LAST) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end else begin
          r_stable  <= r_s2[g];
          r_cnt     <= '0;
          r_press   <= r_s2[g];
          r_release <= ~r_s2[g];
        end
      end
    end

    assign w_stable[g]  = r_stable;
    assign w_press[g]   = r_press;
    assign w_release[g] = r_release;
  end

  // Run/stop toggle driven by accepted presses on channel 0; releases are ignored.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_STOPPED;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      if (w_press[0]) begin
        case (r_state)
          ST_STOPPED: begin
            r_state <= ST_RUNNING;
            r_start <= 1'b1;
          end
          default: begin
            r_state <= ST_STOPPED;
            r_stop  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign btn_level   = w_stable;
  assign btn_press   = w_press;
  assign btn_release = w_release;
  assign run         = (r_state == ST_RUNNING);
  assign start_pulse = r_start;
  assign stop_pulse  = r_stop;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Directed bench for pushbutton_conditioner (NUM_BTN=3, DEBOUNCE_CYCLES=8).
// Expected pulse events are queued with the edge number they must appear on;
// a negedge monitor compares every pulse output against the queue each cycle.
module tb_pushbutton_conditioner;

  localparam int NB = 3;
  localparam int DC = 8;

  // Bit positions in the monitored pulse vector.
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int R0 = 3;
  localparam int R1 = 4;
  localparam int R2 = 5;
  localparam int ST = 6;
  localparam int SP = 7;

  logic          clock;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          run;
  logic          start_pulse;
  logic          stop_pulse;

  typedef struct {
    int bitn;
    int at;
  } ev_t;

  ev_t  q[$];
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mon_obs;
  logic [7:0] mon_exp;

  pushbutton_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .run        (run),
    .start_pulse(start_pulse),
    .stop_pulse (stop_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) edge_n <= edge_n + 1;

  task automatic exp_ev(input int bitn, input int at);
    q.push_back('{bitn, at});
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_edge(input int target);
    while (edge_n < target) @(negedge clock);
  endtask

  // Every cycle: pulses expected on this edge vs pulses seen.
  always @(negedge clock) begin
    mon_obs = {stop_pulse, start_pulse, btn_release, btn_press};
    mon_exp = '0;
    for (int j = q.size() - 1; j >= 0; j--) begin
      if (q[j].at == edge_n) begin
        mon_exp[q[j].bitn] = 1'b1;
        q.delete(j);
      end
    end
    for (int b = 0; b < 8; b++) begin
      checks++;
      assert (mon_obs[b] === mon_exp[b]) else begin
        errors++;
        $error("FAIL pulse bit%0d edge %0d: observed=%b expected=%b",
               b, edge_n, mon_obs[b], mon_exp[b]);
      end
    end
  end

  initial begin
    int k;
    btn_raw = '0;
    reset   = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_level",   32'(btn_level),   32'h0);
    check("rst_press",   32'(btn_press),   32'h0);
    check("rst_release", 32'(btn_release), 32'h0);
    check("rst_run",     32'(run),         32'h0);
    check("rst_start",   32'(start_pulse), 32'h0);
    check("rst_stop",    32'(stop_pulse),  32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Clean press on channel 0 starts the run.
    btn_raw[0] = 1'b1;
    k = edge_n + 1;
    exp_ev(P0, k + 9);
    exp_ev(ST, k + 10);
    wait_edge(k + 12);
    check("t1_level", 32'(btn_level), 32'h1);
    check("t1_run",   32'(run),       32'h1);
    btn_raw[0] = 1'b0;
    k = edge_n + 1;
    exp_ev(R0, k + 9);
    wait_edge(k + 12);
    check("t1_rel_level", 32'(btn_level), 32'h0);
    check("t1_rel_run",   32'(run),       32'h1);

    // Bounce on channel 1: no run of highs reaches the debounce length.
    btn_raw[1] = 1'b1; repeat (3) @(negedge clock);
    btn_raw[1] = 1'b0; repeat (2) @(negedge clock);
    btn_raw[1] = 1'b1; repeat (5) @(negedge clock);
    btn_raw[1] = 1'b0; repeat (12) @(negedge clock);
    check("t2_bounce_level", 32'(btn_level), 32'h0);
    btn_raw[1] = 1'b1;
    k = edge_n + 1;
    exp_ev(P1, k + 9);
    repeat (12) @(negedge clock);
    check("t2_hold_level", 32'(btn_level), 32'h2);
    check("t2_hold_run",   32'(run),       32'h1);
    btn_raw[1] = 1'b0;
    k = edge_n + 1;
    exp_ev(R1, k + 9);
    wait_edge(k + 12);

    // Second press on channel 0 stops the run.
    btn_raw[0] = 1'b1;
    k = edge_n + 1;
    exp_ev(P0, k + 9);
    exp_ev(SP, k + 10);
    wait_edge(k + 12);
    check("t3_level", 32'(btn_level), 32'h1);
    check("t3_run",   32'(run),       32'h0);
    btn_raw[0] = 1'b0;
    k = edge_n + 1;
    exp_ev(R0, k + 9);
    wait_edge(k + 12);
    check("t3_rel_run", 32'(run), 32'h0);

    // Channels 0 and 2 rise together.
    btn_raw = 3'b101;
    k = edge_n + 1;
    exp_ev(P0, k + 9);
    exp_ev(P2, k + 9);
    exp_ev(ST, k + 10);
    wait_edge(k + 12);
    check("t4_level", 32'(btn_level), 32'h5);
    check("t4_run",   32'(run),       32'h1);
    btn_raw = 3'b000;
    k = edge_n + 1;
    exp_ev(R0, k + 9);
    exp_ev(R2, k + 9);
    wait_edge(k + 12);
    check("t4_rel_level", 32'(btn_level), 32'h0);

    // Reset while channel 0 is mid-count (count 5), button held throughout.
    btn_raw[0] = 1'b1;
    k = edge_n + 1;
    wait_edge(k + 6);
    reset = 1'b1;
    #1;
    check("t5_rst_run",   32'(run),         32'h0);
    check("t5_rst_level", 32'(btn_level),   32'h0);
    check("t5_rst_press", 32'(btn_press),   32'h0);
    check("t5_rst_start", 32'(start_pulse), 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    k = edge_n + 1;
    exp_ev(P0, k + 9);
    exp_ev(ST, k + 10);
    wait_edge(k + 12);
    check("t5_level", 32'(btn_level), 32'h1);
    check("t5_run",   32'(run),       32'h1);
    btn_raw[0] = 1'b0;
    k = edge_n + 1;
    exp_ev(R0, k + 9);
    wait_edge(k + 12);

    // One sample short of the debounce length on channel 2.
    btn_raw[2] = 1'b1;
    repeat (DC - 1) @(negedge clock);
    btn_raw[2] = 1'b0;
    repeat (16) @(negedge clock);
    check("t6_level", 32'(btn_level), 32'h0);
    check("t6_run",   32'(run),       32'h1);

    repeat (4) @(negedge clock);
    check("no_pending", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pushbutton_conditioner.md
Name: pushbutton_conditioner

Overview:
- Front-end stage for the board push buttons.
- Synchronises and debounces NUM_BTN raw button inputs, and produces clean levels plus single-cycle press and release pulses.
- Channel 0 also drives a run/stop toggle, so one button produces the start/stop pulses consumed by the stopwatch counter stage directly downstream.
- Runs on the 50 MHz board clock.

Parameters:
- NUM_BTN, 3: number of button channels; minimum 1.
- DEBOUNCE_CYCLES, 1000000: clock cycles a synchronised level must hold before it is accepted (20 ms at 50 MHz); minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width. Derived; never overridden.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- btn_raw, input, NUM_BTN: raw asynchronous button levels, 1 = pressed.
- btn_level, output, NUM_BTN: debounced button level.
- btn_press, output, NUM_BTN: one-cycle pulse on each accepted 0->1 transition.
- btn_release, output, NUM_BTN: one-cycle pulse on each accepted 1->0 transition.
- run, output, 1: toggle state; 1 = timing running.
- start_pulse, output, 1: one-cycle pulse when run goes 0->1.
- stop_pulse, output, 1: one-cycle pulse when run goes 1->0.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high; ports are named clock and reset. All flops reset asynchronously.
- Reset values: every output is 0. Synchroniser flops, stable registers and counters are also 0.
- Synchroniser: two flops per channel, btn_raw -> s1 -> s2. Only s2 is used downstream.
- Debounce, per channel, independent of the others:
  - If s2 == stable, the counter clears to 0.
  - If s2 != stable and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If s2 != stable and counter == DEBOUNCE_CYCLES-1:
    - stable <= s2 and counter <= 0.
    - btn_press <= s2; btn_release <= ~s2.
  - Otherwise btn_press and btn_release are 0 (registered pulses, exactly one cycle wide).
  - btn_level = stable.
- Latency: new raw level first sampled at edge k; btn_level and the press/release pulse update at edge k+DEBOUNCE_CYCLES+1.
- Glitch rejection: any cycle with s2 == stable, including a bounce back to the old level, restarts the count from 0. A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_level.
- Counter never exceeds DEBOUNCE_CYCLES-1. There is no wrap-around.
- Toggle (channel 0), evaluated at the edge after btn_press[0] is high:
  - run <= ~run.
  - start_pulse <= ~run (old value).
  - stop_pulse <= run (old value).
  - start_pulse and stop_pulse are never high together and are 0 in all other cycles.
- Release on channel 0 does not affect run.
- Other channels only provide level and pulses. Their downstream use is a top-level decision: e.g. channel 1 as a reset request.
- Reset mid-debounce or mid-pulse:
  - Outputs drop to 0 immediately (asynchronous).
  - A button still held after reset deasserts is accepted as a fresh press after the full latency.
- Outputs never depend combinationally on btn_raw.

Test Plan (sim with DEBOUNCE_CYCLES=8, NUM_BTN=3):
1. Clean press: btn_raw[0] goes 0->1, sampled at edge k, held -> btn_level[0]=1 and btn_press[0]=1 for exactly one cycle at edge k+9. At edge k+10: start_pulse=1 for one cycle, run=1. btn_release stays 0.
2. Bounce: btn_raw[1] toggles high 3 cycles, low 2, high 5, low -> btn_level[1] stays 0 and no pulses on btn_press[1] or btn_release[1]. Then hold high for 12 cycles -> exactly one btn_press[1] pulse.
3. Second press on channel 0 after a full release (run=1) -> one stop_pulse, run=0, start_pulse stays 0. The release edges produce one btn_release[0] pulse each; run is unchanged by them.
4. Independence: btn_raw[0] and btn_raw[2] rise on the same edge -> btn_press[0] and btn_press[2] pulse in the same cycle. btn_raw[1] is unaffected.
5. Reset mid-debounce: assert reset at count 5 with btn_raw[0]=1 held -> all outputs 0 immediately. After deassert, btn_press[0] pulses 9 edges after the first post-reset sample.
6. Exactly DEBOUNCE_CYCLES-1 = 7 stable cycles then back low -> no level change and no pulses.
